// File: rtl/link_rx.sv
`default_nettype none
// ============================================================================
//  Module   : link_rx
//  Purpose  : Inbound NoC byte-link receiver. Reassembles PKT_BYTES bytes
//             (MSB first) into one packet word, buffers completed packets in
//             a DEPTH-entry circular FIFO and returns the free flow-control
//             signal to the sender.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock            in   rising-edge clock
//    reset_n          in   asynchronous active-low reset
//    put_inbound      in   a valid byte is on payload_inbound this cycle
//    payload_inbound  in   link byte [7:0]
//    free_outbound    out  receiver can accept one whole new packet
//    pkt_out          out  head-of-FIFO packet [8*PKT_BYTES-1:0]
//    pkt_out_avail    out  FIFO not empty
//    pkt_out_read     in   consumer pops the head (ignored when empty)
//    overflow         out  sticky: a packet arrived with no space
// ============================================================================
module link_rx #(
  parameter int PKT_BYTES = 4,
  parameter int DEPTH     = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     put_inbound,
  input  logic [7:0]               payload_inbound,
  output logic                     free_outbound,
  output logic [8*PKT_BYTES-1:0]   pkt_out,
  output logic                     pkt_out_avail,
  input  logic                     pkt_out_read,
  output logic                     overflow
);

  localparam int PW     = 8 * PKT_BYTES;
  localparam int CNT_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1) + 1;

  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]      asm_q,      asm_d;
  logic               discard_q,  discard_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [OCC_W-1:0]   count_q,    count_d;
  logic [PW-1:0]      mem_q [DEPTH];
  logic [PW-1:0]      mem_d [DEPTH];

  logic               assembling;
  logic               fifo_full;
  logic               drop_now;
  logic               do_push;
  logic               do_pop;
  logic [OCC_W-1:0]   occupancy;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    discard_d  = discard_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    do_push    = 1'b0;

    assembling = (byte_cnt_q != '0);
    fifo_full  = (count_q == OCC_W'(DEPTH));
    do_pop     = pkt_out_read && (count_q != '0);
    // The keep/drop decision is taken on byte 0 and held for the rest of
    // the packet so the link stays framed even while discarding.
    drop_now   = (byte_cnt_q == '0) ? fifo_full : discard_q;

    if (put_inbound) begin
      // Truncating cast keeps the low PW bits: shift left by one byte.
      asm_d = PW'({asm_q, payload_inbound});
      if ((byte_cnt_q == '0) && fifo_full) begin
        overflow_d = 1'b1;
      end
      if (byte_cnt_q == CNT_W'(PKT_BYTES - 1)) begin
        byte_cnt_d = '0;
        discard_d  = 1'b0;
        do_push    = !drop_now;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        discard_d  = drop_now;
      end
    end

    if (do_push) begin
      mem_d[wr_ptr_q] = asm_d;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    // A push can never find the FIFO full: the slot was reserved at byte 0.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
      discard_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      discard_q  <= discard_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  // A packet in progress already owns a FIFO slot, so it counts against the
  // space offered to the sender. Only registers and reset_n feed this.
  assign occupancy     = count_q + OCC_W'(assembling);
  assign free_outbound = reset_n && (occupancy < OCC_W'(DEPTH));
  assign pkt_out       = mem_q[rd_ptr_q];
  assign pkt_out_avail = (count_q != '0);
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: doc/link_rx.md
# link_rx

Inbound link receiver for the NoC byte link. It sits at the receiving end of a node or router port and drives the `free` flow-control signal back to the sender. It samples `put`/`payload` bytes and reassembles each group of PKT_BYTES bytes into one packet word. Completed packets are buffered in a small FIFO and handed to the local consumer through an avail/read handshake.

## Interface
- PKT_BYTES, 4, bytes per packet. The packet word is 8*PKT_BYTES bits.
- DEPTH, 2, FIFO entries (≥1).

- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- put_inbound  input  1  a valid byte is on payload_inbound this cycle.
- payload_inbound  input  8  link byte.
- free_outbound  output  1  receiver can accept one whole new packet.
- pkt_out  output  8*PKT_BYTES  head-of-FIFO packet.
- pkt_out_avail  output  1  FIFO not empty.
- pkt_out_read  input  1  consumer pops the head; ignored when pkt_out_avail=0.
- overflow  output  1  sticky: a packet arrived with no space.

## Operation
- **Link protocol.**
  - The sender samples free_outbound at a rising edge. If it was 1, the sender may start one packet in any later cycle.
  - Bytes are sent MSB first. Byte 0 is pkt[8*PKT_BYTES-1 -: 8].
  - Idle cycles (put_inbound=0) between bytes of one packet are legal. The byte counter advances only on put_inbound=1.
  - Packets never interleave.
- **Assembly.**
  - byte_cnt runs 0..PKT_BYTES-1.
  - Each accepted byte shifts into the assembly register: asm <= {asm[..-8], payload_inbound}.
  - When byte_cnt = PKT_BYTES-1, the next accepted byte completes the packet. The full word is written to the FIFO tail and byte_cnt wraps to 0.
- **Commitment.**
  - `assembling` is 1 while byte_cnt≠0.
  - free_outbound = reset_n & ((count + assembling) < DEPTH).
  - free_outbound is driven from registers and reset_n only. It has no combinational path from put_inbound or pkt_out_read.
- **Drop.**
  - If byte 0 of a packet is sampled while (count + assembling) == DEPTH, the whole packet is discarded. A `discard` flag is set for PKT_BYTES bytes and the FIFO is untouched.
  - overflow is set and stays 1 until reset.
  - Byte counting continues normally, so the link stays framed.
- **FIFO.**
  - Circular buffer with DEPTH entries. Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH. pkt_out = mem[rd_ptr].
  - Pop happens when pkt_out_read & pkt_out_avail.
- **Simultaneous events.**
  - Packet completion and pop in the same cycle are both performed, and count is unchanged.
  - This is legal even at count == DEPTH. Space is guaranteed by commitment, so completion never finds the FIFO full.

## Timing
- **Reset** (asynchronous, while reset_n=0): byte_cnt=0, count=0, pointers=0, discard=0, overflow=0, pkt_out_avail=0, free_outbound=0, pkt_out = 0 (memory cleared).
- **After reset release:** free_outbound=1 in the first cycle.
- **Latency:** final byte sampled at edge k → pkt_out_avail=1 and pkt_out valid after edge k. Minimum packet latency is PKT_BYTES cycles, first byte to avail.
- **Pop:** takes effect at the edge where pkt_out_read=1. The next entry, or avail=0, is visible after that edge.
- **free_outbound update:** falls after the edge that samples byte 0 of the packet filling the last slot. Rises after the edge of the pop that frees a slot.
- **Reset mid-packet:** partial packet lost. The sender must restart from byte 0.
- **Throughput:** back-to-back packets with no idle cycles are sustained when the consumer pops every completed packet the cycle it appears.

## Test plan
- **Single packet.** Reset, then put bytes A1,B2,C3,D4 on 4 consecutive cycles → pkt_out=32'hA1B2C3D4 with avail=1 after the 4th edge. Pop → avail=0.
- **Gapped bytes.** Send 11, idle 2 cycles, 22, 33, idle 1 cycle, 44 → pkt_out=32'h11223344. overflow=0.
- **Fill and free.** Hold pkt_out_read=0.
  - Send packet P0=32'h01020304 → free stays 1.
  - Send P1=32'h05060708 → free drops after P1 byte 0 is sampled.
  - Pop P0 → free rises next cycle; pkt_out=P1.
- **Overflow.** With the FIFO full (DEPTH=2), send 32'hDEADBEEF → FIFO contents unchanged, overflow=1 and stays 1.
  - Pop both entries, then send 32'hCAFEF00D → it is received correctly.
- **Simultaneous.** count=2 wait — use count=1 with assembly in progress: pop asserted on the same edge the final byte arrives → count stays 1. pkt_out shows the newly completed packet.
- **Reset mid-packet.** Send AA,BB, then pulse reset_n low → all outputs go to reset values immediately. Then send 10,20,30,40 → pkt_out=32'h10203040.
